zkbdmus_evq: RTL

ZKBDMUS_EVQ -- requirements
Module: zkbdmus_evq

---
 rtl/zkbdmus_evq_if.sv | 40 ++++
 rtl/zkbdmus_evq.sv | 120 ++++++++++++
 2 files changed

// File: rtl/zkbdmus_evq_if.sv
// rtl/zkbdmus_evq_if.sv - bus bundle for the keyboard/mouse event block
// master: host side, drives strobes, data, row address and read selects
// slave : device side, returns column read, mouse data and event FIFO status
interface zkbdmus_evq_if #(
   parameter int ROWS      = 8,
   parameter int COLS      = 5,
   parameter int EVQ_DEPTH = 8
);
   localparam int NKEYS = ROWS * COLS;
   localparam int KW    = $clog2(NKEYS);
   localparam int EW    = KW + 1;
   localparam int CW    = $clog2(EVQ_DEPTH + 1);

   logic [NKEYS-1:0] kbd_in;
   logic             kbd_stb;
   logic [7:0]       mus_in;
   logic [1:0]       mus_wsel;
   logic             mus_stb;
   logic             mus_delta;
   logic [ROWS-1:0]  zah;
   logic [COLS-1:0]  kbd_data;
   logic [1:0]       mus_rsel;
   logic [7:0]       mus_data;
   logic             ev_rd;
   logic [EW-1:0]    ev_data;
   logic             ev_empty;
   logic [CW-1:0]    ev_count;

   modport master (
      output kbd_in, kbd_stb, mus_in, mus_wsel, mus_stb, mus_delta,
             zah, mus_rsel, ev_rd,
      input  kbd_data, mus_data, ev_data, ev_empty, ev_count
   );

   modport slave (
      input  kbd_in, kbd_stb, mus_in, mus_wsel, mus_stb, mus_delta,
             zah, mus_rsel, ev_rd,
      output kbd_data, mus_data, ev_data, ev_empty, ev_count
   );
endinterface

// File: rtl/zkbdmus_evq.sv
// rtl/zkbdmus_evq.sv - keyboard matrix scanner with key-event FIFO and mouse registers
// fclk : clock, all state on rising edge
// rst  : synchronous active-high reset
// bus  : slave side of zkbdmus_evq_if (matrix load/read, mouse write/read, event FIFO)
module zkbdmus_evq #(
   parameter int ROWS      = 8,
   parameter int COLS      = 5,
   parameter int EVQ_DEPTH = 8,
   parameter int MUS_AXES  = 3
) (
   input  logic          fclk,
   input  logic          rst,
   zkbdmus_evq_if.slave  bus
);
   localparam int NKEYS = ROWS * COLS;
   localparam int KW    = $clog2(NKEYS);
   localparam int EW    = KW + 1;
   localparam int CW    = $clog2(EVQ_DEPTH + 1);
   localparam int AW    = $clog2(EVQ_DEPTH);

   logic [NKEYS-1:0] kbd;
   logic [NKEYS-1:0] shd;
   logic [KW-1:0]    idx;
   logic [EW-1:0]    mem [EVQ_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [7:0]       btn;
   logic [7:0]       axis [1:MUS_AXES];

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [COLS-1:0]  kd;
   logic [7:0]       md;

   // Full is taken from the occupancy before this edge, so a same-cycle pop
   // never makes room for a push; the key is simply retried next pass.
   assign full  = (count == CW'(EVQ_DEPTH));
   assign empty = (count == '0);
   assign push  = (kbd[idx] != shd[idx]) && !full;
   assign pop   = bus.ev_rd && !empty;

   always_ff @(posedge fclk) begin
      if (rst) begin
         kbd    <= '0;
         shd    <= '0;
         idx    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         btn    <= 8'hFF;
         for (int a = 1; a <= MUS_AXES; a++) begin
            axis[a] <= 8'h00;
         end
      end else begin
         if (bus.kbd_stb) begin
            kbd <= bus.kbd_in;
         end
         idx <= (idx == KW'(NKEYS - 1)) ? '0 : idx + KW'(1);
         // Shadow only follows the matrix when the event was actually queued.
         if (push) begin
            shd[idx] <= kbd[idx];
            wr_ptr   <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
         if (bus.mus_stb) begin
            if (bus.mus_wsel == 2'd0) begin
               btn <= bus.mus_in;
            end
            for (int a = 1; a <= MUS_AXES; a++) begin
               if (bus.mus_wsel == 2'(a)) begin
                  axis[a] <= bus.mus_delta ? axis[a] + bus.mus_in : bus.mus_in;
               end
            end
         end
      end
   end

   // Storage needs no reset; occupancy and pointers define what is valid.
   always_ff @(posedge fclk) begin
      if (push) begin
         mem[wr_ptr] <= {kbd[idx], idx};
      end
   end

   // Column is pulled low by any pressed key on an addressed (low) row.
   always_comb begin
      kd = '1;
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            if (!bus.zah[r] && kbd[c*ROWS + r]) begin
               kd[c] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      md = 8'hFF;
      if (bus.mus_rsel == 2'd0) begin
         md = btn;
      end
      for (int a = 1; a <= MUS_AXES; a++) begin
         if (bus.mus_rsel == 2'(a)) begin
            md = axis[a];
         end
      end
   end

   assign bus.kbd_data = kd;
   assign bus.mus_data = md;
   assign bus.ev_data  = mem[rd_ptr];
   assign bus.ev_empty = empty;
   assign bus.ev_count = count;
endmodule
